// File: rtl/alu_issue_arbiter_if.sv
// Bundle of the request, ALU and response channels around alu_issue_arbiter.
//   req_valid/req_ready : per-requester handshake, packed op/a/b per requester
//   alu_op_*            : operands driven to the shared combinational ALU
//   alu_out/alu_*flags  : ALU result and flags returned to the arbiter
//   resp_*              : valid/ready response channel tagged with requester id
//   busy                : arbiter is not idle
// slave  = arbiter side, master = issue/ALU/consumer side.
interface alu_issue_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [5*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;

  logic [4:0]            alu_op_code;
  logic [31:0]           alu_op_a;
  logic [31:0]           alu_op_b;
  logic [31:0]           alu_out;
  logic                  alu_carry;
  logic                  alu_overflow;
  logic                  alu_parity;
  logic                  alu_neg;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic [4:0]            resp_flags;
  logic                  resp_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  alu_out, alu_carry, alu_overflow, alu_parity, alu_neg,
    input  resp_ready,
    output req_ready, alu_op_code, alu_op_a, alu_op_b,
    output resp_valid, resp_id, resp_data, resp_flags, resp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output alu_out, alu_carry, alu_overflow, alu_parity, alu_neg,
    output resp_ready,
    input  req_ready, alu_op_code, alu_op_a, alu_op_b,
    input  resp_valid, resp_id, resp_data, resp_flags, resp_err, busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU among NUM_REQ requesters.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_issue_arbiter_if.slave (request, ALU and response channels)
// Flow: IDLE grants and latches one op into the ALU input registers, EXEC captures the
// ALU result/flags one cycle later, RESP holds the tagged response until accepted.
module alu_issue_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_issue_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [NUM_REQ-1:0] ReqOne    = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LastReset = ID_W'(NUM_REQ - 1);
  localparam logic [4:0]         OpAdd     = 5'd16;
  localparam logic [4:0]         OpSub     = 5'd17;

  state_e          state_q, state_d;
  // last_grant doubles as the pending id: it is written on every transfer and not
  // touched again until the next IDLE transfer.
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [4:0]      alu_op_code_q, alu_op_code_d;
  logic [31:0]     alu_op_a_q, alu_op_a_d;
  logic [31:0]     alu_op_b_q, alu_op_b_d;
  logic            resp_valid_q, resp_valid_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [4:0]      resp_flags_q, resp_flags_d;
  logic            resp_err_q, resp_err_d;
  logic            busy_q, busy_d;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] valid_rot;
  logic [31:0]        search_idx;
  logic [4:0]         op_sel;
  logic [31:0]        a_sel;
  logic [31:0]        b_sel;
  logic               op_reserved;
  logic               carry_ok;

  // Search from last_grant+1 with wrap; first valid requester wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    valid_rot  = '0;
    search_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      search_idx = (32'(last_grant_q) + k) % NUM_REQ;
      valid_rot  = bus.req_valid >> search_idx;
      if (!grant_vld && valid_rot[0]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(search_idx);
      end
    end
  end

  // Gated by rst_n so req_ready reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && grant_vld) begin
      req_ready = ReqOne << grant_idx;
    end
  end

  always_comb begin
    op_sel = 5'(bus.req_op >> (32'd5 * 32'(grant_idx)));
    a_sel  = 32'(bus.req_a >> (32'd32 * 32'(grant_idx)));
    b_sel  = 32'(bus.req_b >> (32'd32 * 32'(grant_idx)));
  end

  // Reserved op codes: 9-15 and 20-31.
  always_comb begin
    op_reserved = ((alu_op_code_q >= 5'd9) && (alu_op_code_q <= 5'd15)) ||
                  (alu_op_code_q >= 5'd20);
    // The ALU carry line is only meaningful for ADD/SUB; otherwise it is stale.
    carry_ok    = (alu_op_code_q == OpAdd) || (alu_op_code_q == OpSub);
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    alu_op_code_d = alu_op_code_q;
    alu_op_a_d    = alu_op_a_q;
    alu_op_b_d    = alu_op_b_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_data_d   = resp_data_q;
    resp_flags_d  = resp_flags_q;
    resp_err_d    = resp_err_q;

    case (state_q)
      StIdle: begin
        if (grant_vld) begin
          alu_op_code_d = op_sel;
          alu_op_a_d    = a_sel;
          alu_op_b_d    = b_sel;
          last_grant_d  = grant_idx;
          state_d       = StExec;
        end
      end
      StExec: begin
        resp_data_d  = bus.alu_out;
        resp_flags_d = {(bus.alu_out == 32'd0), bus.alu_neg, bus.alu_parity,
                        bus.alu_overflow, (carry_ok & bus.alu_carry)};
        resp_err_d   = op_reserved;
        resp_id_d    = last_grant_q;
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (bus.resp_ready) begin
          resp_valid_d  = 1'b0;
          alu_op_code_d = 5'd0;
          alu_op_a_d    = 32'd0;
          alu_op_b_d    = 32'd0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_grant_q  <= LastReset;
      alu_op_code_q <= 5'd0;
      alu_op_a_q    <= 32'd0;
      alu_op_b_q    <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= 32'd0;
      resp_flags_q  <= 5'd0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      alu_op_code_q <= alu_op_code_d;
      alu_op_a_q    <= alu_op_a_d;
      alu_op_b_q    <= alu_op_b_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
      resp_flags_q  <= resp_flags_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.alu_op_code = alu_op_code_q;
  assign bus.alu_op_a    = alu_op_a_q;
  assign bus.alu_op_b    = alu_op_b_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_flags  = resp_flags_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ID_W    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- ALU reference (also drives the DUT's ALU inputs) ----------------
  function automatic logic [31:0] alu_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      5'd0:  return 32'd0;
      5'd1:  return a & b;
      5'd2:  return a | b;
      5'd3:  return a ^ b;
      5'd4:  return ~a;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'($signed(a) >>> b[4:0]);
      5'd8:  return b;
      5'd16: return a + b;
      5'd17: return a - b;
      5'd18: return a + 32'd1;
      5'd19: return a - 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // {carry, overflow} for ADD/SUB, zero otherwise.
  function automatic logic [1:0] alu_cv(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    if (op == 5'd16) begin
      s = {1'b0, a} + {1'b0, b};
      return {s[32], (a[31] == b[31]) && (s[31] != a[31])};
    end else if (op == 5'd17) begin
      s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      return {s[32], (a[31] != b[31]) && (s[31] != a[31])};
    end
    return 2'b00;
  endfunction

  logic [1:0] cv_w;
  logic       addsub_w;
  logic       stale_c = 1'b1;
  assign cv_w     = alu_cv(bus.alu_op_code, bus.alu_op_a, bus.alu_op_b);
  assign addsub_w = (bus.alu_op_code == 5'd16) || (bus.alu_op_code == 5'd17);
  assign bus.alu_out      = alu_res(bus.alu_op_code, bus.alu_op_a, bus.alu_op_b);
  // Carry line keeps its last ADD/SUB value for other ops.
  assign bus.alu_carry    = addsub_w ? cv_w[1] : stale_c;
  assign bus.alu_overflow = cv_w[0];
  assign bus.alu_parity   = ^bus.alu_out;
  assign bus.alu_neg      = bus.alu_out[31];
  always @(posedge clk) if (addsub_w) stale_c <= cv_w[1];

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int rr_ptr = NUM_REQ - 1;

  function automatic int model_grant(input int ptr, input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (ptr + k) % NUM_REQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  // Called in an idle cycle just after a falling edge; returns likewise.
  task automatic run_txn(input logic [NUM_REQ-1:0] mask, input logic [5*NUM_REQ-1:0] ops,
                         input logic [32*NUM_REQ-1:0] as, input logic [32*NUM_REQ-1:0] bs,
                         input int stall);
    int g;
    logic [4:0] op;
    logic [31:0] a, b, res;
    logic [1:0] cv;
    logic [4:0] flags;
    logic err;
    logic [NUM_REQ-1:0] exp_rdy;
    bus.req_valid = mask;
    bus.req_op    = ops;
    bus.req_a     = as;
    bus.req_b     = bs;
    #1;
    g = model_grant(rr_ptr, mask);
    check_eq("idle_busy", bus.busy, 0);
    check_eq("idle_resp_valid", bus.resp_valid, 0);
    if (g < 0) begin
      check_eq("no_req_ready", bus.req_ready, 0);
      @(negedge clk); #1;
      check_eq("no_req_stay_idle", bus.busy, 0);
      return;
    end
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    check_eq("grant", bus.req_ready, exp_rdy);
    op = ops[5*g +: 5];
    a  = as[32*g +: 32];
    b  = bs[32*g +: 32];
    rr_ptr = g;

    // EXEC: scramble requests; they must be ignored.
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_op[5*i +: 5] = 5'($urandom_range(0, 31));
      bus.req_a[32*i +: 32] = $urandom;
      bus.req_b[32*i +: 32] = $urandom;
    end
    bus.req_valid = NUM_REQ'($urandom);
    bus.resp_ready = (stall == 0);
    #1;
    check_eq("exec_busy", bus.busy, 1);
    check_eq("exec_ready", bus.req_ready, 0);
    check_eq("exec_resp_valid", bus.resp_valid, 0);
    check_eq("exec_op", bus.alu_op_code, op);
    check_eq("exec_a", bus.alu_op_a, a);
    check_eq("exec_b", bus.alu_op_b, b);

    res   = alu_res(op, a, b);
    cv    = alu_cv(op, a, b);
    flags = {(res == 32'd0), res[31], ^res, cv[0], cv[1]};
    err   = ((op >= 5'd9) && (op <= 5'd15)) || (op >= 5'd20);

    @(negedge clk); #1;
    for (int s = 0; s < ((stall == 0) ? 1 : stall); s++) begin
      if (s > 0) begin
        @(negedge clk); #1;
      end
      check_eq("resp_valid", bus.resp_valid, 1);
      check_eq("resp_id", bus.resp_id, g);
      check_eq("resp_data", bus.resp_data, res);
      check_eq("resp_flags", bus.resp_flags, flags);
      check_eq("resp_err", bus.resp_err, err);
      check_eq("resp_busy", bus.busy, 1);
      check_eq("resp_ready_low", bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;

    @(negedge clk); #1;
    check_eq("done_resp_valid", bus.resp_valid, 0);
    check_eq("done_op_clr", bus.alu_op_code, 0);
    check_eq("done_a_clr", bus.alu_op_a, 0);
    check_eq("done_b_clr", bus.alu_op_b, 0);
    check_eq("done_busy", bus.busy, 0);
  endtask

  logic [5*NUM_REQ-1:0]  t_ops;
  logic [32*NUM_REQ-1:0] t_as, t_bs;
  logic [NUM_REQ-1:0]    all_req;

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      t_ops[5*i +: 5] = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: t_as[32*i +: 32] = 32'd0;
        1: t_as[32*i +: 32] = 32'hFFFF_FFFF;
        default: t_as[32*i +: 32] = $urandom;
      endcase
      t_bs[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    end
  endtask

  initial begin
    all_req = '1;
    bus.req_valid  = all_req;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_op", bus.alu_op_code, 0);
    check_eq("rst_a", bus.alu_op_a, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_data", bus.resp_data, 0);
    check_eq("rst_flags", bus.resp_flags, 0);
    check_eq("rst_busy", bus.busy, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // ADD 0xFFFFFFFF + 1 on requester 0
    t_ops = '0; t_as = '0; t_bs = '0;
    t_ops[4:0] = 5'd16; t_as[31:0] = 32'hFFFF_FFFF; t_bs[31:0] = 32'd1;
    run_txn(3'b001, t_ops, t_as, t_bs, 0);

    // SUB 5-3 then AND: carry must be masked for AND
    t_ops[4:0] = 5'd17; t_as[31:0] = 32'd5; t_bs[31:0] = 32'd3;
    run_txn(3'b001, t_ops, t_as, t_bs, 0);
    t_ops[4:0] = 5'd1; t_as[31:0] = 32'hF0; t_bs[31:0] = 32'h3C;
    run_txn(3'b001, t_ops, t_as, t_bs, 0);

    // Reserved op 12 on requester 1
    t_ops[9:5] = 5'd12; t_as[63:32] = 32'h1234; t_bs[63:32] = 32'h5678;
    run_txn(3'b010, t_ops, t_as, t_bs, 0);

    // NOP on requester 2
    t_ops[14:10] = 5'd0; t_as[95:64] = 32'hDEAD; t_bs[95:64] = 32'hBEEF;
    run_txn(3'b100, t_ops, t_as, t_bs, 0);

    // No requests: stays idle
    run_txn(3'b000, t_ops, t_as, t_bs, 0);

    // Round robin, all valid, XOR ops, back to back
    for (int n = 0; n < 6; n++) begin
      rand_ops();
      for (int i = 0; i < NUM_REQ; i++) t_ops[5*i +: 5] = 5'd3;
      run_txn(all_req, t_ops, t_as, t_bs, 0);
    end

    // Backpressure
    rand_ops();
    run_txn(all_req, t_ops, t_as, t_bs, 5);
    rand_ops();
    run_txn(all_req, t_ops, t_as, t_bs, 2);

    // Reset during EXEC with requester 1 granted
    t_ops[4:0] = 5'd16; t_as[31:0] = 32'd7; t_bs[31:0] = 32'd8;
    run_txn(3'b001, t_ops, t_as, t_bs, 0);
    rand_ops();
    bus.req_valid = all_req;
    bus.req_op = t_ops; bus.req_a = t_as; bus.req_b = t_bs;
    #1;
    check_eq("rstmid_grant", bus.req_ready, 3'b010);
    @(negedge clk); #1;
    check_eq("rstmid_exec_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_busy", bus.busy, 0);
    check_eq("rstmid_op", bus.alu_op_code, 0);
    check_eq("rstmid_b", bus.alu_op_b, 0);
    check_eq("rstmid_resp_valid", bus.resp_valid, 0);
    check_eq("rstmid_resp_data", bus.resp_data, 0);
    check_eq("rstmid_resp_id", bus.resp_id, 0);
    check_eq("rstmid_ready", bus.req_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rr_ptr = NUM_REQ - 1;
    bus.req_valid = '0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_eq("rstmid_no_resp", bus.resp_valid, 0);
      @(negedge clk);
    end
    #1;
    rand_ops();
    run_txn(all_req, t_ops, t_as, t_bs, 0);

    // Randomized
    for (int n = 0; n < 80; n++) begin
      rand_ops();
      run_txn(NUM_REQ'($urandom), t_ops, t_as, t_bs, $urandom_range(0, 3));
    end

    bus.req_valid = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single combinational 32-bit ALU between NUM_REQ requesters (decode/execute, address-gen, debug).
- Round-robin arbitration; accepted operation latched into ALU input registers; ALU result and flags captured one cycle later.
- Result returned on a valid/ready response channel tagged with the requester id.
- Sits between issue logic and the ALU; sole driver of ALU op_code/op_a/op_b.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of resp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_op  in  5*NUM_REQ  packed ALU op codes; requester i at [5i+4:5i].
- req_a  in  32*NUM_REQ  packed operand A; requester i at [32i+31:32i].
- req_b  in  32*NUM_REQ  packed operand B.
- alu_op_code  out  5  to ALU op_code.
- alu_op_a  out  32  to ALU op_a.
- alu_op_b  out  32  to ALU op_b.
- alu_out  in  32  ALU result.
- alu_carry, alu_overflow, alu_parity, alu_neg  in  1 each  ALU flags.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_data  out  32  captured result.
- resp_flags  out  5  {zero, neg, parity, overflow, carry}.
- resp_err  out  1  op code was reserved (9-15, 20-31).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0; alu_op_code=0 (NOP), alu_op_a=alu_op_b=0; resp_valid=0, resp_id=0, resp_data=0, resp_flags=0, resp_err=0; busy=0; rr pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: one-hot grant to the first requester with valid=1, searching from last_grant+1 with wrap modulo NUM_REQ.
  - Transfer occurs when req_valid[g] & req_ready[g].
  - On transfer: latch req_op/a/b of g into alu_op_* registers, store g as pending id and as last_grant, then go to EXEC.
  - No valid requests: stay in IDLE; last_grant unchanged.
- EXEC (1 cycle): ALU settles. At the clock edge:
  - resp_data <= alu_out.
  - zero <= (alu_out==0); neg, parity, overflow taken directly from the ALU.
  - carry <= alu_carry only for op 16 (ADD) or 17 (SUB); otherwise 0. The ALU's carry output is stale for other ops.
  - resp_err <= reserved-op decode.
  - resp_id <= pending id.
  - resp_valid <= 1; go to RESP.
- RESP:
  - resp_* held stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready: resp_valid <= 0; alu_op_code/op_a/op_b <= 0; go to IDLE.
- req_ready is 0 in EXEC and RESP; requesters hold their requests.
- Latency: accept edge to resp_valid high is 2 clocks. Minimum initiation interval is 3 clocks per op.
- Reserved op codes are issued normally (ALU returns 0); resp_err=1 and zero flag=1.
- NOP (op 0) is a legal op: data 0, zero=1, err=0.
- resp_ready may already be high when RESP is entered: the handshake completes in the first RESP cycle.
- Request changes while not ready: ignored. Only values present at the transfer edge are used.
- Reset asserted mid-operation: the in-flight op is dropped and no response is produced. After release, the first grant goes to requester 0.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0.
- busy=1 in EXEC and RESP.

Test Plan:
- Single request: req0 ADD a=0xFFFFFFFF, b=0x1 → accepted; 2 clocks later resp_valid=1, resp_id=0, data=0x00000000, zero=1, carry=1, err=0.
- Carry masking: SUB a=5 b=3, then AND a=0xF0 b=0x3C on the same requester → AND response data=0x30, carry=0 even though the ALU carry line still holds the SUB value.
- Round robin: both requesters valid continuously with XOR ops → grant order 0,1,0,1; each response id matches; one op completes every 3 clocks with resp_ready tied high.
- Backpressure: resp_ready=0 for 5 clocks after resp_valid → resp_data/id/flags stable; req_ready stays 0 for a waiting requester; it is granted the cycle after resp_ready goes high.
- Reserved op: req1 op=5'd12 → data=0, err=1, zero=1, resp_id=1.
- Reset mid-op: assert rst_n=0 during EXEC with req1 granted → all outputs return to reset values immediately; no response after release; with both requesters valid after release, requester 0 is granted first.
